ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_valid  input  1  ID-stage instruction valid.
REQ-005 i_jump, i_branch, i_regDst, i_mem2Reg, i_regWrite, i_memRead, i_memWrite, i_immediate  input  1 each  decoded ID controls.
REQ-006 i_aluSrc, i_aluOp  input  2 each  decoded ID ALU controls.
REQ-007 i_rs, i_rt, i_rd  input  REG_ADDR_W each  ID register fields.
REQ-008 i_branch_taken  input  1  branch resolution of the instruction in EX.
REQ-009 o_stall  output  1  freeze PC and IF/ID this cycle.
REQ-010 o_flush  output  1  kill the IF/ID instruction this cycle.
REQ-011 o_ex_valid, o_ex_branch, o_ex_immediate  output  1 each; o_ex_aluSrc, o_ex_aluOp  output  2 each  EX-stage controls.
REQ-012 o_mem_memRead, o_mem_memWrite  output  1 each  MEM-stage controls.
REQ-013 o_wb_regWrite, o_wb_mem2Reg  output  1 each; o_wb_dst  output  REG_ADDR_W  WB-stage write controls.
REQ-014 o_fwd_a, o_fwd_b  output  2 each  EX operand forwarding select: 00 regfile, 01 from WB, 10 from MEM.

Function
REQ-015 Block SHALL hold three stage registers (ID/EX, EX/MEM, MEM/WB), each with valid, controls, dst; ID/EX additionally holds rs, rt.
REQ-016 Latency: ID controls SHALL appear on o_ex_* 1 cycle, o_mem_* 2 cycles, o_wb_* 3 cycles after capture.
REQ-017 dst SHALL be selected at ID->EX capture: i_regDst ? i_rd : i_rt.
REQ-018 regWrite SHALL be forced 0 at capture when selected dst = 0.
REQ-019 A bubble is valid=0 with all controls 0; i_valid=0 SHALL capture as a bubble.
REQ-020 Load-use: o_stall SHALL be 1 when ID/EX valid & memRead & dst!=0 & (dst==i_rs or (dst==i_rt and rt used)), rt used = (i_aluSrc==00) | i_memWrite | i_branch, and i_valid=1.
REQ-021 On stall, ID/EX SHALL capture a bubble; EX/MEM and MEM/WB SHALL advance normally.
REQ-022 Taken branch: ID/EX valid & branch & i_branch_taken SHALL assert o_flush and capture a bubble into ID/EX; o_stall SHALL be 0 that cycle.
REQ-023 Jump: i_valid & i_jump in ID (no taken branch) SHALL assert o_flush; the jump SHALL enter ID/EX with regWrite, memRead, memWrite forced 0.
REQ-024 Simultaneous taken branch and jump in ID: branch SHALL win; jump captured as bubble.
REQ-025 o_fwd_a SHALL be 10 if EX/MEM valid & regWrite & dst==ID/EX rs, else 01 if MEM/WB valid & regWrite & dst==ID/EX rs, else 00; o_fwd_b identical against ID/EX rt.
REQ-026 o_stall, o_flush, o_fwd_* SHALL be combinational from inputs and stage registers; all other outputs SHALL be registered.

Reset
REQ-027 i_rst=1 SHALL immediately clear all stage registers; every output SHALL be 0 while reset is asserted.
REQ-028 Reset mid-operation SHALL discard all in-flight instructions; first valid ID after deassert SHALL appear on o_ex_* at the next rising edge.

Verification
REQ-029 R-type (regDst=1, rd=5, regWrite=1) then 3 bubbles -> o_wb_regWrite=1, o_wb_dst=5 exactly 3 cycles after capture.
REQ-030 lw dst=3 then add rs=3 -> o_stall=1 one cycle, one bubble on o_ex_valid, add reaches EX next cycle with o_fwd_a=01.
REQ-031 add dst=4 then sub rs=4, rt=4 back-to-back -> o_fwd_a=o_fwd_b=10 with sub in EX.
REQ-032 beq in EX with i_branch_taken=1 while jump in ID -> o_flush=1, o_stall=0, next o_ex_valid=0.
REQ-033 R-type with rd=0, regWrite=1 -> o_wb_regWrite=0; no forwarding (o_fwd_*=00) to a following rs=0 consumer.
REQ-034 Assert i_rst with three valid instructions in flight -> all outputs 0 same cycle; after release, pipeline refills from empty.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-path pipeline for a 5-stage in-order core: carries decoded controls
// from ID through EX/MEM/WB and resolves load-use stalls, flushes and forwarding.
module ctrl_pipeline #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_jump,
  input  logic                  i_branch,
  input  logic                  i_regDst,
  input  logic                  i_mem2Reg,
  input  logic                  i_regWrite,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic                  i_immediate,
  input  logic [1:0]            i_aluSrc,
  input  logic [1:0]            i_aluOp,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_branch_taken,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic                  o_ex_valid,
  output logic                  o_ex_branch,
  output logic                  o_ex_immediate,
  output logic [1:0]            o_ex_aluSrc,
  output logic [1:0]            o_ex_aluOp,
  output logic                  o_mem_memRead,
  output logic                  o_mem_memWrite,
  output logic                  o_wb_regWrite,
  output logic                  o_wb_mem2Reg,
  output logic [REG_ADDR_W-1:0] o_wb_dst,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic                  branch;
    logic                  immediate;
    logic [1:0]            alu_src;
    logic [1:0]            alu_op;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem2reg;
    logic [REG_ADDR_W-1:0] dst;
  } stage_t;

  stage_t                id_ex_q, ex_mem_q, mem_wb_q;
  stage_t                id_ex_d;
  logic [REG_ADDR_W-1:0] id_ex_rs_q, id_ex_rt_q;
  logic [REG_ADDR_W-1:0] id_ex_rs_d, id_ex_rt_d;

  logic [REG_ADDR_W-1:0] sel_dst;
  logic                  branch_taken;
  logic                  rt_used;
  logic                  load_use;
  logic                  stall;
  logic                  jump_flush;
  fwd_sel_t              fwd_a, fwd_b;

  // Hazard detection against the instruction currently sitting in ID
  always_comb begin
    sel_dst      = i_regDst ? i_rd : i_rt;
    branch_taken = id_ex_q.valid & id_ex_q.branch & i_branch_taken;
    rt_used      = (i_aluSrc == 2'b00) | i_memWrite | i_branch;
    load_use     = i_valid & id_ex_q.valid & id_ex_q.mem_read
                 & (id_ex_q.dst != '0)
                 & ((id_ex_q.dst == i_rs) | ((id_ex_q.dst == i_rt) & rt_used));
    stall        = load_use & ~branch_taken;
    // A stalled jump stays in ID, so its fetch shadow is not killed yet
    jump_flush   = i_valid & i_jump & ~branch_taken & ~stall;
    o_stall      = stall & ~i_rst;
    o_flush      = (branch_taken | jump_flush) & ~i_rst;
  end

  always_comb begin
    id_ex_d    = '0;
    id_ex_rs_d = '0;
    id_ex_rt_d = '0;
    if (i_valid & ~branch_taken & ~stall) begin
      id_ex_d.valid     = 1'b1;
      id_ex_d.branch    = i_branch;
      id_ex_d.immediate = i_immediate;
      id_ex_d.alu_src   = i_aluSrc;
      id_ex_d.alu_op    = i_aluOp;
      id_ex_d.mem_read  = i_memRead & ~i_jump;
      id_ex_d.mem_write = i_memWrite & ~i_jump;
      id_ex_d.reg_write = i_regWrite & ~i_jump & (sel_dst != '0);
      id_ex_d.mem2reg   = i_mem2Reg;
      id_ex_d.dst       = sel_dst;
      id_ex_rs_d        = i_rs;
      id_ex_rt_d        = i_rt;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      id_ex_q    <= '0;
      ex_mem_q   <= '0;
      mem_wb_q   <= '0;
      id_ex_rs_q <= '0;
      id_ex_rt_q <= '0;
    end else begin
      id_ex_q    <= id_ex_d;
      id_ex_rs_q <= id_ex_rs_d;
      id_ex_rt_q <= id_ex_rt_d;
      ex_mem_q   <= id_ex_q;
      mem_wb_q   <= ex_mem_q;
    end
  end

  // MEM has priority: it holds the younger, more recent producer
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_mem_q.valid & ex_mem_q.reg_write & (ex_mem_q.dst == id_ex_rs_q))
      fwd_a = FWD_MEM;
    else if (mem_wb_q.valid & mem_wb_q.reg_write & (mem_wb_q.dst == id_ex_rs_q))
      fwd_a = FWD_WB;
    if (ex_mem_q.valid & ex_mem_q.reg_write & (ex_mem_q.dst == id_ex_rt_q))
      fwd_b = FWD_MEM;
    else if (mem_wb_q.valid & mem_wb_q.reg_write & (mem_wb_q.dst == id_ex_rt_q))
      fwd_b = FWD_WB;
  end

  assign o_fwd_a        = fwd_a;
  assign o_fwd_b        = fwd_b;

  assign o_ex_valid     = id_ex_q.valid;
  assign o_ex_branch    = id_ex_q.branch;
  assign o_ex_immediate = id_ex_q.immediate;
  assign o_ex_aluSrc    = id_ex_q.alu_src;
  assign o_ex_aluOp     = id_ex_q.alu_op;
  assign o_mem_memRead  = ex_mem_q.mem_read;
  assign o_mem_memWrite = ex_mem_q.mem_write;
  assign o_wb_regWrite  = mem_wb_q.reg_write;
  assign o_wb_mem2Reg   = mem_wb_q.mem2reg;
  assign o_wb_dst       = mem_wb_q.dst;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboarded bench for ctrl_pipeline: directed hazard scenarios followed by
// randomized traffic checked against an instruction-level pipeline model.
module tb_ctrl_pipeline;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0, i_jump = 1'b0, i_branch = 1'b0, i_regDst = 1'b0;
  logic         i_mem2Reg = 1'b0, i_regWrite = 1'b0, i_memRead = 1'b0, i_memWrite = 1'b0;
  logic         i_immediate = 1'b0;
  logic [1:0]   i_aluSrc = '0, i_aluOp = '0;
  logic [W-1:0] i_rs = '0, i_rt = '0, i_rd = '0;
  logic         i_branch_taken = 1'b0;
  logic         o_stall, o_flush, o_ex_valid, o_ex_branch, o_ex_immediate;
  logic [1:0]   o_ex_aluSrc, o_ex_aluOp, o_fwd_a, o_fwd_b;
  logic         o_mem_memRead, o_mem_memWrite, o_wb_regWrite, o_wb_mem2Reg;
  logic [W-1:0] o_wb_dst;

  always #5 clk = ~clk;

  ctrl_pipeline #(.REG_ADDR_W(W)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_jump(i_jump), .i_branch(i_branch),
    .i_regDst(i_regDst), .i_mem2Reg(i_mem2Reg), .i_regWrite(i_regWrite),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_immediate(i_immediate),
    .i_aluSrc(i_aluSrc), .i_aluOp(i_aluOp), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_branch_taken(i_branch_taken), .o_stall(o_stall), .o_flush(o_flush),
    .o_ex_valid(o_ex_valid), .o_ex_branch(o_ex_branch), .o_ex_immediate(o_ex_immediate),
    .o_ex_aluSrc(o_ex_aluSrc), .o_ex_aluOp(o_ex_aluOp), .o_mem_memRead(o_mem_memRead),
    .o_mem_memWrite(o_mem_memWrite), .o_wb_regWrite(o_wb_regWrite),
    .o_wb_mem2Reg(o_wb_mem2Reg), .o_wb_dst(o_wb_dst), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b)
  );

  typedef struct packed {
    logic valid, jump, branch, regDst, mem2Reg, regWrite, memRead, memWrite, immediate;
    logic [1:0] aluSrc, aluOp;
    logic [W-1:0] rs, rt, rd;
    logic taken;
  } id_t;

  // One in-flight instruction as seen by the model
  typedef struct packed {
    logic valid, branch, imm;
    logic [1:0] src, op;
    logic mr, mw, rw, m2r;
    logic [W-1:0] dst, rs, rt;
  } slot_t;

  typedef struct {
    int           cyc;
    logic [5:0]   haz;
    logic [6:0]   ex;
    logic [W+3:0] mw;
  } exp_t;

  slot_t pipe [3];   // [0] in EX, [1] in MEM, [2] in WB
  exp_t  expq [$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    last_stall = 1'b0;

  function automatic logic [1:0] producer(input logic [W-1:0] r);
    if (pipe[1].valid && pipe[1].rw && pipe[1].dst == r) return 2'b10;
    if (pipe[2].valid && pipe[2].rw && pipe[2].dst == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step(input id_t in, input bit rst, output exp_t e);
    logic [W-1:0] dst;
    bit taken, needs_rt, hazard, stall, flush, writes;
    slot_t nxt;
    e.cyc = cyc;
    e.haz = '0; e.ex = '0; e.mw = '0;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      last_stall = 1'b0;
    end else begin
      taken    = pipe[0].valid && pipe[0].branch && in.taken;
      dst      = in.regDst ? in.rd : in.rt;
      needs_rt = (in.aluSrc == 2'b00) || in.memWrite || in.branch;
      hazard   = in.valid && pipe[0].valid && pipe[0].mr && pipe[0].dst != 0 &&
                 (pipe[0].dst == in.rs || (needs_rt && pipe[0].dst == in.rt));
      stall    = hazard && !taken;
      flush    = taken || (in.valid && in.jump && !stall);
      e.haz = {stall, flush, producer(pipe[0].rs), producer(pipe[0].rt)};
      e.ex  = {pipe[0].valid, pipe[0].branch, pipe[0].imm, pipe[0].src, pipe[0].op};
      e.mw  = {pipe[1].mr, pipe[1].mw, pipe[2].rw, pipe[2].m2r, pipe[2].dst};
      nxt = '0;
      if (in.valid && !taken && !stall) begin
        writes = in.regWrite && !in.jump && dst != 0;
        nxt = '{valid: 1'b1, branch: in.branch, imm: in.immediate, src: in.aluSrc,
                op: in.aluOp, mr: in.memRead && !in.jump, mw: in.memWrite && !in.jump,
                rw: writes, m2r: in.mem2Reg, dst: dst, rs: in.rs, rt: in.rt};
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
      last_stall = stall;
    end
  endtask

  task automatic step(input id_t in, input bit rst);
    exp_t e;
    @(negedge clk);
    i_rst = rst;
    i_valid = in.valid; i_jump = in.jump; i_branch = in.branch; i_regDst = in.regDst;
    i_mem2Reg = in.mem2Reg; i_regWrite = in.regWrite; i_memRead = in.memRead;
    i_memWrite = in.memWrite; i_immediate = in.immediate; i_aluSrc = in.aluSrc;
    i_aluOp = in.aluOp; i_rs = in.rs; i_rt = in.rt; i_rd = in.rd; i_branch_taken = in.taken;
    model_step(in, rst, e);
    expq.push_back(e);
    cyc++;
  endtask

  function automatic id_t rtype(input int rs, input int rt, input int rd);
    id_t x = '0;
    x.valid = 1; x.regDst = 1; x.regWrite = 1; x.aluOp = 2'b10;
    x.rs = W'(rs); x.rt = W'(rt); x.rd = W'(rd);
    return x;
  endfunction

  function automatic id_t lw(input int rs, input int rt);
    id_t x = '0;
    x.valid = 1; x.memRead = 1; x.mem2Reg = 1; x.regWrite = 1; x.aluSrc = 2'b01;
    x.immediate = 1; x.rs = W'(rs); x.rt = W'(rt);
    return x;
  endfunction

  function automatic id_t beq(input int rs, input int rt);
    id_t x = '0;
    x.valid = 1; x.branch = 1; x.aluOp = 2'b01; x.rs = W'(rs); x.rt = W'(rt);
    return x;
  endfunction

  function automatic id_t jmp();
    id_t x = '0;
    x.valid = 1; x.jump = 1; x.regWrite = 1;
    return x;
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if ({o_stall, o_flush, o_fwd_a, o_fwd_b} !== e.haz) begin
          errors++;
          $display("FAIL hazard cyc=%0d got=%b exp=%b (stall,flush,fwd_a,fwd_b)", e.cyc,
                   {o_stall, o_flush, o_fwd_a, o_fwd_b}, e.haz);
        end
        checks++;
        if ({o_ex_valid, o_ex_branch, o_ex_immediate, o_ex_aluSrc, o_ex_aluOp} !== e.ex) begin
          errors++;
          $display("FAIL ex_stage cyc=%0d got=%b exp=%b", e.cyc,
                   {o_ex_valid, o_ex_branch, o_ex_immediate, o_ex_aluSrc, o_ex_aluOp}, e.ex);
        end
        checks++;
        if ({o_mem_memRead, o_mem_memWrite, o_wb_regWrite, o_wb_mem2Reg, o_wb_dst} !== e.mw) begin
          errors++;
          $display("FAIL mem_wb cyc=%0d got=%b exp=%b", e.cyc,
                   {o_mem_memRead, o_mem_memWrite, o_wb_regWrite, o_wb_mem2Reg, o_wb_dst}, e.mw);
        end
      end
    end
  end

  initial begin
    id_t nop, x, prev;
    nop = '0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;

    step(jmp(), 1'b1);
    step(nop, 1'b1);
    // Writeback latency of an R-type
    step(rtype(1, 2, 5), 1'b0);
    repeat (4) step(nop, 1'b0);
    // Load-use: add is held in ID while stalled
    step(lw(1, 3), 1'b0);
    step(rtype(3, 2, 8), 1'b0);
    step(rtype(3, 2, 8), 1'b0);
    repeat (3) step(nop, 1'b0);
    // Back-to-back dependency forwarded from MEM on both operands
    step(rtype(1, 2, 4), 1'b0);
    step(rtype(4, 4, 6), 1'b0);
    repeat (3) step(nop, 1'b0);
    // Taken branch in EX beats a jump in ID
    step(beq(1, 2), 1'b0);
    x = jmp(); x.taken = 1'b1;
    step(x, 1'b0);
    step(jmp(), 1'b0);
    repeat (3) step(nop, 1'b0);
    // Write to register 0 is suppressed and never forwarded
    step(rtype(1, 2, 0), 1'b0);
    step(rtype(0, 0, 7), 1'b0);
    repeat (3) step(nop, 1'b0);
    // Reset with three instructions in flight, then refill
    step(rtype(1, 2, 9), 1'b0);
    step(lw(2, 10), 1'b0);
    step(rtype(9, 10, 11), 1'b0);
    step(jmp(), 1'b1);
    step(rtype(1, 2, 12), 1'b1);
    step(rtype(12, 3, 13), 1'b0);
    step(rtype(13, 12, 14), 1'b0);
    repeat (3) step(nop, 1'b0);

    prev = nop;
    for (int n = 0; n < 3000; n++) begin
      if (last_stall) begin
        x = prev;
      end else begin
        x = '0;
        x.valid     = ($urandom_range(0, 9) != 0);
        x.jump      = ($urandom_range(0, 9) == 0);
        x.branch    = ($urandom_range(0, 4) == 0);
        x.regDst    = $urandom_range(0, 1) == 1;
        x.mem2Reg   = $urandom_range(0, 1) == 1;
        x.regWrite  = ($urandom_range(0, 3) != 0);
        x.memRead   = ($urandom_range(0, 2) == 0);
        x.memWrite  = ($urandom_range(0, 4) == 0);
        x.immediate = $urandom_range(0, 1) == 1;
        x.aluSrc    = 2'($urandom_range(0, 3));
        x.aluOp     = 2'($urandom_range(0, 3));
        x.rs        = W'($urandom_range(0, 3));
        x.rt        = W'($urandom_range(0, 3));
        x.rd        = W'($urandom_range(0, 3));
      end
      x.taken = $urandom_range(0, 1) == 1;
      prev = x;
      step(x, $urandom_range(0, 99) == 0);
    end
    step(nop, 1'b0);

    for (int t = 0; t < 10 && expq.size() > 0; t++) @(negedge clk);
    #4;
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
